// File: rtl/ibex_irq_scheduler.sv
// ibex_irq_scheduler: registers interrupt lines, arbitrates by fixed priority and presents one request at a time
module ibex_irq_scheduler #(
    parameter int NumFastIrq = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    irq_software_i,
    input  logic                    irq_timer_i,
    input  logic                    irq_external_i,
    input  logic [NumFastIrq-1:0]   irq_fast_i,
    input  logic                    irq_nm_i,
    input  logic [NumFastIrq+2:0]   mie_i,
    input  logic                    mstatus_mie_i,
    input  logic                    debug_mode_i,
    input  logic                    irq_ack_i,
    input  logic                    mret_i,
    output logic [NumFastIrq+2:0]   irq_pending_o,
    output logic                    irq_req_o,
    output logic [5:0]              irq_cause_o,
    output logic                    nmi_mode_o
);
    localparam int W = NumFastIrq + 3;
    localparam int Ext = NumFastIrq;
    localparam int Tmr = NumFastIrq + 1;
    localparam int Sw = NumFastIrq + 2;
    localparam logic [5:0] CauseNmi = 6'h3F;

    typedef enum logic [1:0] {Idle, Req, NmiAct} state_e;

    state_e state_q, state_d, ret_state;
    logic [W-1:0] pending_q, elig;
    logic [5:0] cause_q, cause_d, win_cause;
    logic req_q, req_d, nmi_mode_q, nmi_mode_d;
    logic nm_q, nm_hist_q, nm_arm_q, nm_latch_q;
    logic nm_edge, nmi_elig, nmi_ack, any_elig, held_ok, cause_nmi;

    function automatic logic [4:0] code_of(int j);
        return j < NumFastIrq ? 5'(16 + j) : j == Ext ? 5'd11 : j == Tmr ? 5'd7 : 5'd3;
    endfunction

    // nm_arm_q blocks an edge from a line that was already high when reset released
    assign nm_edge = nm_q & ~nm_hist_q & nm_arm_q;
    assign cause_nmi = cause_q == CauseNmi;
    assign nmi_elig = nm_latch_q & ~nmi_mode_q;
    assign nmi_ack = state_q == Req && irq_ack_i && cause_nmi;
    assign ret_state = nmi_mode_q ? NmiAct : Idle;

    // eligibility, fixed-priority winner and whether the held cause is still eligible
    always_comb begin
        elig = pending_q & mie_i & {W{mstatus_mie_i}};
        any_elig = |elig;
        held_ok = 1'b0;
        for (int j = 0; j < W; j++) held_ok = held_ok | (elig[j] && code_of(j) == cause_q[4:0]);
        win_cause = {1'b1, code_of(Tmr)};
        if (elig[Sw]) win_cause = {1'b1, code_of(Sw)};
        if (elig[Ext]) win_cause = {1'b1, code_of(Ext)};
        for (int i = NumFastIrq - 1; i >= 0; i--) if (elig[i]) win_cause = {1'b1, code_of(i)};
    end

    // next state: ack beats withdrawal, NMI preempts a held non-NMI request
    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle:    if (!debug_mode_i && (nmi_elig || any_elig)) state_d = Req;
            Req:     if (irq_ack_i) state_d = (cause_nmi || nmi_mode_q) ? NmiAct : Idle;
                     else if (debug_mode_i || (!cause_nmi && !nmi_elig && !held_ok)) state_d = ret_state;
            NmiAct:  if (mret_i) state_d = Idle;
                     else if (!debug_mode_i && any_elig) state_d = Req;
            default: state_d = Idle;
        endcase
    end

    // outputs: cause loads on entry to Req or on NMI preemption, otherwise holds
    always_comb begin
        req_d = state_d == Req;
        cause_d = (req_d && (state_q != Req || nmi_elig)) ? (nmi_elig ? CauseNmi : win_cause) : cause_q;
        nmi_mode_d = nmi_ack ? 1'b1 : (state_q == NmiAct && mret_i) ? 1'b0 : nmi_mode_q;
    end

    // state and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Idle;
            req_q <= 1'b0;
            cause_q <= '0;
            nmi_mode_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            cause_q <= cause_d;
            nmi_mode_q <= nmi_mode_d;
        end
    end

    // input registers, NMI edge history and NMI latch
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            nm_q <= 1'b0;
            nm_hist_q <= 1'b0;
            nm_arm_q <= 1'b0;
            nm_latch_q <= 1'b0;
        end else begin
            pending_q <= {irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
            nm_q <= irq_nm_i;
            nm_hist_q <= nm_q;
            nm_arm_q <= nm_arm_q | ~irq_nm_i;
            nm_latch_q <= ~nmi_ack & (nm_latch_q | nm_edge);
        end
    end

    assign irq_pending_o = pending_q;
    assign irq_req_o = req_q;
    assign irq_cause_o = cause_q;
    assign nmi_mode_o = nmi_mode_q;
endmodule

// File: tb/tb_ibex_irq_scheduler.sv
// tb_ibex_irq_scheduler: directed scenarios plus randomized run against a behavioural model
module tb_ibex_irq_scheduler;
    localparam int NF = 15;
    localparam int W = NF + 3;

    logic clk = 1'b0;
    logic rst, sw, tmr, ext, nm, mstatus, dbg, ack, mret;
    logic [NF-1:0] fast;
    logic [W-1:0] mie, pend;
    logic req, nmi_mode;
    logic [5:0] cause;
    int vectors = 0;
    int errors = 0;

    logic [W-1:0] m_pend;
    logic [5:0] m_cause;
    bit m_req, m_nmi, m_latch, m_nm1, m_nm2, m_arm;

    always #5 clk = ~clk;

    ibex_irq_scheduler #(.NumFastIrq(NF)) dut (
        .clk_i(clk), .rst_i(rst), .irq_software_i(sw), .irq_timer_i(tmr),
        .irq_external_i(ext), .irq_fast_i(fast), .irq_nm_i(nm), .mie_i(mie),
        .mstatus_mie_i(mstatus), .debug_mode_i(dbg), .irq_ack_i(ack), .mret_i(mret),
        .irq_pending_o(pend), .irq_req_o(req), .irq_cause_o(cause), .nmi_mode_o(nmi_mode)
    );

    function automatic logic [5:0] src_cause(int j);
        return j < NF ? 6'(48 + j) : j == NF ? 6'h2B : j == NF + 1 ? 6'h27 : 6'h23;
    endfunction

    task automatic model_step();
        logic [W-1:0] el;
        int order[$];
        bit any, held, took_nmi, nm_rise, nmi_ok;
        logic [5:0] best;
        if (rst) begin
            m_pend = '0; m_cause = '0; m_req = 0; m_nmi = 0;
            m_latch = 0; m_nm1 = 0; m_nm2 = 0; m_arm = 0;
            return;
        end
        el = m_pend & mie & {W{mstatus}};
        for (int i = 0; i < NF; i++) order.push_back(i);
        order.push_back(NF);
        order.push_back(NF + 2);
        order.push_back(NF + 1);
        any = 0;
        best = '0;
        foreach (order[k]) if (!any && el[order[k]]) begin any = 1; best = src_cause(order[k]); end
        held = 0;
        for (int j = 0; j < W; j++) if (el[j] && src_cause(j) == m_cause) held = 1;
        nm_rise = m_nm1 && !m_nm2 && m_arm;
        nmi_ok = m_latch && !m_nmi;
        took_nmi = 0;
        if (m_req) begin
            if (ack) begin took_nmi = m_cause == 6'h3F; m_nmi = m_nmi | took_nmi; m_req = 0; end
            else if (dbg) m_req = 0;
            else if (nmi_ok) m_cause = 6'h3F;
            else if (!held) m_req = 0;
        end else if (m_nmi && mret) m_nmi = 0;
        else if (!dbg && (nmi_ok || any)) begin m_req = 1; m_cause = nmi_ok ? 6'h3F : best; end
        m_latch = !took_nmi && (m_latch || nm_rise);
        m_nm2 = m_nm1;
        m_nm1 = nm;
        m_arm = m_arm || !nm;
        m_pend = {sw, tmr, ext, fast};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 0; sw = 0; tmr = 0; ext = 0; nm = 0; mstatus = 0;
        dbg = 0; ack = 0; mret = 0; fast = '0; mie = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; tmr = 1; ext = 1; nm = 1; mie = '1; mstatus = 1;
        tick();
        tick();
        vectors++;
        if (req !== 1'b0 || cause !== 6'h00 || nmi_mode !== 1'b0 || pend !== '0) begin
            errors++;
            $display("FAIL reset: req=%b cause=%h nmi=%b pend=%h, want all zero", req, cause, nmi_mode, pend);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_timer();
        mie = '0; mie[NF+1] = 1; mstatus = 1; tmr = 1;
        tick();
        vectors++;
        if (req !== 1'b0 || pend !== W'(1) << (NF + 1)) begin
            errors++;
            $display("FAIL timer_latency: req=%b pend=%h, want 0 and %h", req, pend, W'(1) << (NF + 1));
        end
        tick();
        vectors++;
        if (req !== 1'b1 || cause !== 6'h27) begin
            errors++;
            $display("FAIL timer_req: req=%b cause=%h, want 1/27", req, cause);
        end
        ack = 1; tmr = 0;
        tick();
        vectors++;
        if (req !== 1'b0) begin errors++; $display("FAIL timer_ack: req=%b, want 0", req); end
        ack = 0;
        tick();
        tick();
    endtask

    task automatic test_priority();
        mie = '1; mstatus = 1; fast = NF'(4); ext = 1; sw = 1;
        tick();
        tick();
        vectors++;
        if (req !== 1'b1 || cause !== 6'h32) begin
            errors++;
            $display("FAIL priority: req=%b cause=%h, want 1/32", req, cause);
        end
        ack = 1; fast = '0; ext = 0; sw = 0;
        tick();
        ack = 0;
        tick();
    endtask

    task automatic test_withdrawal();
        mie = '1; mstatus = 1; ext = 1;
        tick();
        tick();
        vectors++;
        if (req !== 1'b1 || cause !== 6'h2B) begin
            errors++;
            $display("FAIL withdraw_req: req=%b cause=%h, want 1/2b", req, cause);
        end
        ext = 0;
        tick();
        vectors++;
        if (req !== 1'b1) begin errors++; $display("FAIL withdraw_hold: req=%b, want 1", req); end
        tick();
        vectors++;
        if (req !== 1'b0 || cause !== 6'h2B) begin
            errors++;
            $display("FAIL withdraw_drop: req=%b cause=%h, want 0/2b", req, cause);
        end
        ext = 1;
        tick();
        tick();
        vectors++;
        if (req !== 1'b1) begin errors++; $display("FAIL withdraw_rereq: req=%b, want 1", req); end
        ext = 0;
        tick();
        ack = 1;
        tick();
        ack = 0;
        vectors++;
        if (req !== 1'b0 || cause !== 6'h2B) begin
            errors++;
            $display("FAIL withdraw_ack: req=%b cause=%h, want 0/2b", req, cause);
        end
        tick();
        vectors++;
        if (req !== 1'b0) begin errors++; $display("FAIL withdraw_idle: req=%b, want 0", req); end
    endtask

    task automatic test_nmi();
        mie = '0; mie[NF+1] = 1; mstatus = 1; tmr = 1;
        tick();
        tick();
        nm = 1;
        tick();
        nm = 0;
        tick();
        vectors++;
        if (req !== 1'b1 || cause !== 6'h27) begin
            errors++;
            $display("FAIL nmi_before: req=%b cause=%h, want 1/27", req, cause);
        end
        tick();
        vectors++;
        if (req !== 1'b1 || cause !== 6'h3F) begin
            errors++;
            $display("FAIL nmi_preempt: req=%b cause=%h, want 1/3f", req, cause);
        end
        ack = 1; tmr = 0;
        tick();
        ack = 0;
        vectors++;
        if (req !== 1'b0 || nmi_mode !== 1'b1) begin
            errors++;
            $display("FAIL nmi_ack: req=%b nmi=%b, want 0/1", req, nmi_mode);
        end
        nm = 1;
        tick();
        nm = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (req !== 1'b0 || nmi_mode !== 1'b1) begin
                errors++;
                $display("FAIL nmi_second: req=%b nmi=%b, want 0/1", req, nmi_mode);
            end
        end
        mret = 1;
        tick();
        mret = 0;
        vectors++;
        if (nmi_mode !== 1'b0 || req !== 1'b0) begin
            errors++;
            $display("FAIL nmi_mret: nmi=%b req=%b, want 0/0", nmi_mode, req);
        end
    endtask

    task automatic test_masking();
        do_reset();
        mie = '1; fast = '1; sw = 1; tmr = 1; ext = 1; mstatus = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (req !== 1'b0) begin errors++; $display("FAIL mask_mstatus: req=%b, want 0", req); end
        end
        mstatus = 1; dbg = 1; nm = 1;
        tick();
        nm = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (req !== 1'b0) begin errors++; $display("FAIL mask_debug: req=%b, want 0", req); end
        end
        dbg = 0;
        tick();
        vectors++;
        if (req !== 1'b1 || cause !== 6'h3F) begin
            errors++;
            $display("FAIL mask_release: req=%b cause=%h, want 1/3f", req, cause);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_req();
        mie = '0; mie[NF+1] = 1; mstatus = 1; tmr = 1;
        tick();
        tick();
        vectors++;
        if (req !== 1'b1) begin errors++; $display("FAIL rstreq_pre: req=%b, want 1", req); end
        nm = 1; rst = 1;
        tick();
        vectors++;
        if (req !== 1'b0 || cause !== 6'h00 || nmi_mode !== 1'b0 || pend !== '0) begin
            errors++;
            $display("FAIL rstreq_reset: req=%b cause=%h nmi=%b pend=%h, want all zero", req, cause, nmi_mode, pend);
        end
        rst = 0; tmr = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (req !== 1'b0 || nmi_mode !== 1'b0) begin
                errors++;
                $display("FAIL rstreq_no_nmi: req=%b nmi=%b, want 0/0", req, nmi_mode);
            end
        end
        nm = 0;
        tick();
        tick();
        vectors++;
        if (req !== 1'b0) begin errors++; $display("FAIL rstreq_after: req=%b, want 0", req); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            rst = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 3) == 0) sw = ~sw;
            if ($urandom_range(0, 3) == 0) tmr = ~tmr;
            if ($urandom_range(0, 3) == 0) ext = ~ext;
            if ($urandom_range(0, 2) == 0) fast[$urandom_range(0, NF - 1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) nm = ~nm;
            if ($urandom_range(0, 7) == 0) mie = W'($urandom | $urandom);
            mstatus = $urandom_range(0, 7) != 0;
            dbg = $urandom_range(0, 15) == 0;
            ack = $urandom_range(0, 2) == 0;
            mret = $urandom_range(0, 7) == 0;
            tick();
            vectors++;
            if ({req, cause, nmi_mode, pend} !== {m_req, m_cause, m_nmi, m_pend}) begin
                errors++;
                $display("FAIL random[%0d]: req=%b cause=%h nmi=%b pend=%h, want req=%b cause=%h nmi=%b pend=%h",
                         k, req, cause, nmi_mode, pend, m_req, m_cause, m_nmi, m_pend);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_timer();
        test_priority();
        test_withdrawal();
        test_nmi();
        do_reset();
        test_masking();
        test_reset_mid_req();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
